// File: rtl/ram_2p_arb_pkg.sv
// ram_2p_arb_pkg: shared types for the two-port RAM request arbiter
package ram_2p_arb_pkg;

    localparam int MaxIdxW = 8;

    typedef enum logic {INIT, RUN} state_e;

    typedef struct packed {
        logic               valid;
        logic [MaxIdxW-1:0] idx;
    } port_sel_t;

    function automatic logic [MaxIdxW-1:0] wrap_inc(input logic [MaxIdxW-1:0] i, input int n);
        return (int'(i) + 1 >= n) ? '0 : i + MaxIdxW'(1);
    endfunction

endpackage

// File: rtl/ram_2p_rr_pick2.sv
// ram_2p_rr_pick2: rotate-priority picker returning the first two requesters found from ptr upward
module ram_2p_rr_pick2 import ram_2p_arb_pkg::*; #(
    parameter int NumReq = 4
) (
    input  logic [NumReq-1:0]  req,
    input  logic [MaxIdxW-1:0] ptr,
    output port_sel_t          first,
    output port_sel_t          second
);
    localparam int IdxW = $clog2(NumReq);

    logic [IdxW-1:0] j;

    always_comb begin
        first = '0;
        second = '0;
        j = '0;
        for (int k = 0; k < NumReq; k++) begin
            j = IdxW'((int'(ptr) + k) % NumReq);
            if (req[j] && !first.valid) first = '{valid: 1'b1, idx: MaxIdxW'(j)};
            else if (req[j] && !second.valid) second = '{valid: 1'b1, idx: MaxIdxW'(j)};
        end
    end

endmodule

// File: rtl/ram_2p_req_arb.sv
// ram_2p_req_arb: shares both ports of a two-port RAM among NumReq requesters,
// zero-filling the array after reset or on request before granting.
module ram_2p_req_arb import ram_2p_arb_pkg::*; #(
    parameter int  NumReq = 4,
    parameter int  Width  = 32,
    parameter int  Depth  = 128,
    localparam int Aw     = $clog2(Depth)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq-1:0]             req_i,
    input  logic [NumReq-1:0]             write_i,
    input  logic [NumReq-1:0][Aw-1:0]     addr_i,
    input  logic [NumReq-1:0][Width-1:0]  wdata_i,
    input  logic [NumReq-1:0][Width-1:0]  wmask_i,
    output logic [NumReq-1:0]             gnt_o,
    output logic [NumReq-1:0]             rvalid_o,
    output logic [NumReq-1:0][Width-1:0]  rdata_o,
    input  logic                          init_req_i,
    output logic                          init_busy_o,
    output logic                          ram_a_req_o,
    output logic                          ram_a_write_o,
    output logic [Aw-1:0]                 ram_a_addr_o,
    output logic [Width-1:0]              ram_a_wdata_o,
    output logic [Width-1:0]              ram_a_wmask_o,
    input  logic [Width-1:0]              ram_a_rdata_i,
    output logic                          ram_b_req_o,
    output logic                          ram_b_write_o,
    output logic [Aw-1:0]                 ram_b_addr_o,
    output logic [Width-1:0]              ram_b_wdata_o,
    output logic [Width-1:0]              ram_b_wmask_o,
    input  logic [Width-1:0]              ram_b_rdata_i
);
    if (Depth % 2 != 0 || Depth < 4) begin : g_bad_depth
        $error("Depth must be even and at least 4");
    end
    if (NumReq < 2 || NumReq > 2 ** MaxIdxW) begin : g_bad_numreq
        $error("NumReq out of range");
    end

    state_e                       state;
    logic [Aw-2:0]                cnt;
    logic [MaxIdxW-1:0]           ptr;
    port_sel_t                    first, second, tag_a, tag_b;
    logic [NumReq-1:0][Width-1:0] rdata_q;
    logic                         run, init, pa, pb, conflict, ca_write, cb_write;
    logic [Aw-1:0]                ca_addr, cb_addr;
    logic [Width-1:0]             ca_wdata, cb_wdata, ca_wmask, cb_wmask;

    ram_2p_rr_pick2 #(.NumReq(NumReq)) u_pick (
        .req    (req_i),
        .ptr    (ptr),
        .first  (first),
        .second (second)
    );

    always_comb begin
        ca_write = 1'b0;
        ca_addr = '0;
        ca_wdata = '0;
        ca_wmask = '0;
        cb_write = 1'b0;
        cb_addr = '0;
        cb_wdata = '0;
        cb_wmask = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (first.idx == MaxIdxW'(i)) {ca_write, ca_addr, ca_wdata, ca_wmask} = {write_i[i], addr_i[i], wdata_i[i], wmask_i[i]};
            if (second.idx == MaxIdxW'(i)) {cb_write, cb_addr, cb_wdata, cb_wmask} = {write_i[i], addr_i[i], wdata_i[i], wmask_i[i]};
        end
        // Same word with any write on it: serve port A only, B retries next cycle
        conflict = ca_addr == cb_addr && (ca_write || cb_write);
        run = state == RUN && !rst_i && !init_req_i;
        init = state == INIT && !rst_i;
        pa = run && first.valid;
        pb = run && second.valid && !conflict;
        gnt_o = '0;
        for (int i = 0; i < NumReq; i++)
            gnt_o[i] = (pa && first.idx == MaxIdxW'(i)) || (pb && second.idx == MaxIdxW'(i));
        init_busy_o = rst_i || state == INIT;
        ram_a_req_o = init || pa;
        ram_a_write_o = init || ca_write;
        ram_a_addr_o = init ? {cnt, 1'b0} : ca_addr;
        ram_a_wdata_o = init ? '0 : ca_wdata;
        ram_a_wmask_o = init ? '1 : ca_wmask;
        ram_b_req_o = init || pb;
        ram_b_write_o = init || cb_write;
        ram_b_addr_o = init ? {cnt, 1'b1} : cb_addr;
        ram_b_wdata_o = init ? '0 : cb_wdata;
        ram_b_wmask_o = init ? '1 : cb_wmask;
    end

    always_comb begin
        rvalid_o = '0;
        rdata_o = '0;
        for (int i = 0; i < NumReq; i++) begin
            rvalid_o[i] = !rst_i && ((tag_a.valid && tag_a.idx == MaxIdxW'(i)) || (tag_b.valid && tag_b.idx == MaxIdxW'(i)));
            rdata_o[i] = rst_i ? '0 :
                         (tag_a.valid && tag_a.idx == MaxIdxW'(i)) ? ram_a_rdata_i :
                         (tag_b.valid && tag_b.idx == MaxIdxW'(i)) ? ram_b_rdata_i : rdata_q[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= INIT;
            cnt <= '0;
            ptr <= '0;
            tag_a <= '0;
            tag_b <= '0;
            rdata_q <= '0;
        end else begin
            if (state == INIT) begin
                cnt <= (cnt == (Aw-1)'(Depth / 2 - 1)) ? '0 : cnt + (Aw-1)'(1);
                if (cnt == (Aw-1)'(Depth / 2 - 1)) state <= RUN;
            end else if (init_req_i) begin
                state <= INIT;
                cnt <= '0;
            end
            if (pb) ptr <= wrap_inc(second.idx, NumReq);
            else if (pa) ptr <= wrap_inc(first.idx, NumReq);
            tag_a <= '{valid: pa && !ca_write, idx: first.idx};
            tag_b <= '{valid: pb && !cb_write, idx: second.idx};
            rdata_q <= rdata_o;
        end
    end

endmodule

// File: tb/tb_ram_2p_req_arb.sv
// tb_ram_2p_req_arb: randomized and directed bench with a behavioural arbiter/RAM reference model
module tb_ram_2p_req_arb;
    localparam int NR = 4, W = 32, D = 8, AW = $clog2(D);
    localparam int CW = 2 * (2 + AW + 2 * W);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, init_req = 1'b0;
    logic [NR-1:0] req = '0, wr = '0;
    logic [NR-1:0][AW-1:0] addr = '0;
    logic [NR-1:0][W-1:0] wdata = '0, wmask = '0;
    logic [NR-1:0] gnt, rvalid;
    logic [NR-1:0][W-1:0] rdata;
    logic busy, a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [W-1:0] a_wd, a_wm, a_rd, b_wd, b_wm, b_rd;

    ram_2p_req_arb #(.NumReq(NR), .Width(W), .Depth(D)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .write_i(wr), .addr_i(addr),
        .wdata_i(wdata), .wmask_i(wmask), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
        .init_req_i(init_req), .init_busy_o(busy),
        .ram_a_req_o(a_req), .ram_a_write_o(a_we), .ram_a_addr_o(a_addr),
        .ram_a_wdata_o(a_wd), .ram_a_wmask_o(a_wm), .ram_a_rdata_i(a_rd),
        .ram_b_req_o(b_req), .ram_b_write_o(b_we), .ram_b_addr_o(b_addr),
        .ram_b_wdata_o(b_wd), .ram_b_wmask_o(b_wm), .ram_b_rdata_i(b_rd)
    );

    // Two-port RAM with one cycle read latency, standing in for prim_generic_ram_2p
    logic [W-1:0] mem [D];
    initial for (int i = 0; i < D; i++) mem[i] = $urandom;
    always @(posedge clk) begin
        if (a_req && a_we) mem[a_addr] <= (mem[a_addr] & ~a_wm) | (a_wd & a_wm);
        if (a_req && !a_we) a_rd <= mem[a_addr];
        if (b_req && b_we) mem[b_addr] <= (mem[b_addr] & ~b_wm) | (b_wd & b_wm);
        if (b_req && !b_we) b_rd <= mem[b_addr];
    end

    int n_cmp = 0, n_fail = 0;
    int m_ptr = 0, m_init_left = D / 2;
    logic [W-1:0] m_mem [D];
    logic [NR-1:0] m_rv = '0;
    logic [NR-1:0][W-1:0] m_rd = '0;
    logic [NR-1:0] o_gnt, o_rv, e_gnt, e_rv;
    logic [NR-1:0][W-1:0] o_rd, e_rd;
    logic o_busy, e_busy;
    logic [CW-1:0] o_cmd;
    logic [W-1:0] saved_d;

    // One clock of stimulus: sample DUT at the falling edge, form expectations, advance the model
    task automatic drive_cycle();
        int order[$];
        int last;
        @(negedge clk);
        o_gnt = gnt; o_rv = rvalid; o_rd = rdata; o_busy = busy;
        o_cmd = {a_req, a_we, a_addr, a_wd, a_wm, b_req, b_we, b_addr, b_wd, b_wm};
        e_gnt = '0;
        e_busy = rst || m_init_left > 0;
        e_rv = rst ? '0 : m_rv;
        e_rd = rst ? '0 : m_rd;
        m_rv = '0;
        if (rst) begin
            m_init_left = D / 2; m_ptr = 0; m_rd = '0;
        end else if (m_init_left > 0) begin
            m_mem[D - 2 * m_init_left] = '0;
            m_mem[D - 2 * m_init_left + 1] = '0;
            m_init_left--;
        end else if (init_req) begin
            m_init_left = D / 2;
        end else begin
            for (int k = 0; k < NR; k++) if (req[(m_ptr + k) % NR]) order.push_back((m_ptr + k) % NR);
            if (order.size() > 0) e_gnt[order[0]] = 1'b1;
            if (order.size() > 1 && !(addr[order[0]] == addr[order[1]] && (wr[order[0]] || wr[order[1]])))
                e_gnt[order[1]] = 1'b1;
            for (int i = 0; i < NR; i++) if (e_gnt[i] && !wr[i]) begin m_rv[i] = 1'b1; m_rd[i] = m_mem[addr[i]]; end
            for (int i = 0; i < NR; i++) if (e_gnt[i] && wr[i]) m_mem[addr[i]] = (m_mem[addr[i]] & ~wmask[i]) | (wdata[i] & wmask[i]);
            if (order.size() > 0) begin
                last = (order.size() > 1 && e_gnt[order[1]]) ? order[1] : order[0];
                m_ptr = (last + 1) % NR;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic new_op(input int i, input bit allow_write);
        req[i] = 1'b1;
        wr[i] = allow_write ? 1'($urandom_range(1)) : 1'b0;
        addr[i] = AW'($urandom_range(D - 1));
        wdata[i] = $urandom;
        wmask[i] = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '1; wr = '0; init_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (gnt !== '0 || rvalid !== '0 || rdata !== '0 || busy !== 1'b1 || a_req !== 1'b0 || b_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: gnt=%b rvalid=%b rdata=%h busy=%b a_req=%b b_req=%b, required 0/0/0/1/0/0", gnt, rvalid, rdata, busy, a_req, b_req);
        end
        drive_cycle();
        rst = 1'b0;
    endtask

    task automatic test_init_fill();
        logic [CW-1:0] exp_cmd;
        for (int i = 0; i < NR; i++) addr[i] = AW'($urandom_range(D - 1));
        for (int c = 0; c < D / 2; c++) begin
            drive_cycle();
            exp_cmd = {2'b11, AW'(2 * c), W'(0), {W{1'b1}}, 2'b11, AW'(2 * c + 1), W'(0), {W{1'b1}}};
            n_cmp++;
            if (o_cmd !== exp_cmd) begin n_fail++; $display("FAIL init_cmd c=%0d: got %h required %h", c, o_cmd, exp_cmd); end
            n_cmp++;
            if (o_gnt !== '0 || o_busy !== 1'b1) begin n_fail++; $display("FAIL init_gnt c=%0d: gnt=%b busy=%b required 0000/1", c, o_gnt, o_busy); end
        end
        for (int i = 0; i < D; i++) begin
            n_cmp++;
            if (mem[i] !== '0) begin n_fail++; $display("FAIL init_zero addr=%0d: got %h required 0", i, mem[i]); end
        end
    endtask

    task automatic test_all_reads();
        logic [NR-1:0] exp_g [3] = '{4'b0011, 4'b1100, 4'b0000};
        logic [NR-1:0] exp_v [3] = '{4'b0000, 4'b0011, 4'b1100};
        for (int c = 0; c < 3; c++) begin
            drive_cycle();
            n_cmp++;
            if (o_gnt !== exp_g[c] || o_gnt !== e_gnt || o_busy !== 1'b0) begin
                n_fail++; $display("FAIL all_reads_gnt c=%0d: gnt=%b busy=%b required %b/0", c, o_gnt, o_busy, exp_g[c]);
            end
            n_cmp++;
            if (o_rv !== exp_v[c] || o_rd !== e_rd) begin
                n_fail++; $display("FAIL all_reads_rv c=%0d: rvalid=%b rdata=%h required %b/%h", c, o_rv, o_rd, exp_v[c], e_rd);
            end
            req &= ~o_gnt;
        end
    endtask

    task automatic test_conflict();
        saved_d = $urandom | 32'h1;
        req = 4'b0011; wr = 4'b0001; addr[0] = 3'd5; addr[1] = 3'd5; wdata[0] = saved_d; wmask[0] = '1;
        drive_cycle();
        n_cmp++;
        if (o_gnt !== 4'b0001 || o_gnt !== e_gnt) begin n_fail++; $display("FAIL conflict_gnt0: got %b required 0001", o_gnt); end
        req[0] = 1'b0;
        drive_cycle();
        n_cmp++;
        if (o_gnt !== 4'b0010 || o_gnt !== e_gnt) begin n_fail++; $display("FAIL conflict_gnt1: got %b required 0010", o_gnt); end
        req[1] = 1'b0;
        drive_cycle();
        n_cmp++;
        if (o_rv !== 4'b0010 || o_rd[1] !== saved_d) begin
            n_fail++; $display("FAIL conflict_read: rvalid=%b rdata1=%h required 0010/%h", o_rv, o_rd[1], saved_d);
        end
    endtask

    task automatic test_fairness();
        int wt [NR] = '{default: 0};
        req = 4'b1001; wr = '0; addr[0] = 3'd1; addr[3] = 3'd2;
        for (int c = 0; c < 4; c++) begin
            drive_cycle();
            n_cmp++;
            if (o_gnt !== 4'b1001 || o_rv !== e_rv || o_rd !== e_rd) begin
                n_fail++; $display("FAIL fair_pair c=%0d: gnt=%b rvalid=%b required 1001/%b", c, o_gnt, o_rv, e_rv);
            end
        end
        req = '1;
        for (int i = 0; i < NR; i++) addr[i] = AW'(i);
        for (int c = 0; c < 8; c++) begin
            drive_cycle();
            n_cmp++;
            if (o_gnt !== e_gnt) begin n_fail++; $display("FAIL fair_gnt c=%0d: got %b required %b", c, o_gnt, e_gnt); end
            for (int i = 0; i < NR; i++) wt[i] = o_gnt[i] ? 0 : wt[i] + 1;
            n_cmp++;
            if (wt[0] > 1 || wt[1] > 1 || wt[2] > 1 || wt[3] > 1) begin
                n_fail++; $display("FAIL fair_wait c=%0d: waits %0d %0d %0d %0d required <=1", c, wt[0], wt[1], wt[2], wt[3]);
            end
        end
        req = '0;
        drive_cycle();
    endtask

    task automatic test_init_req();
        req = 4'b0001; wr = '0; addr[0] = 3'd5;
        drive_cycle();
        req = '0; init_req = 1'b1;
        drive_cycle();
        n_cmp++;
        if (o_rv !== 4'b0001 || o_rd[0] !== saved_d || o_gnt !== '0) begin
            n_fail++; $display("FAIL init_req_rv: rvalid=%b rdata0=%h gnt=%b required 0001/%h/0000", o_rv, o_rd[0], o_gnt, saved_d);
        end
        init_req = 1'b0; req = '1;
        for (int c = 0; c < D / 2; c++) begin
            drive_cycle();
            n_cmp++;
            if (o_gnt !== '0 || o_busy !== 1'b1) begin n_fail++; $display("FAIL init_req_busy c=%0d: gnt=%b busy=%b required 0000/1", c, o_gnt, o_busy); end
        end
        req = 4'b0001; addr[0] = 3'd5;
        drive_cycle();
        req = '0;
        drive_cycle();
        n_cmp++;
        if (o_rv !== 4'b0001 || o_rd[0] !== '0 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL init_req_zero: rvalid=%b rdata0=%h busy=%b required 0001/0/0", o_rv, o_rd[0], o_busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [CW-1:0] cmd0;
        cmd0 = {2'b11, AW'(0), W'(0), {W{1'b1}}, 2'b11, AW'(1), W'(0), {W{1'b1}}};
        init_req = 1'b1;
        drive_cycle();
        init_req = 1'b0;
        repeat (2) drive_cycle();
        rst = 1'b1;
        drive_cycle();
        n_cmp++;
        if (o_cmd[CW-1] !== 1'b0 || o_cmd[CW/2-1] !== 1'b0 || o_busy !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_init: a_req=%b b_req=%b busy=%b required 0/0/1", o_cmd[CW-1], o_cmd[CW/2-1], o_busy);
        end
        rst = 1'b0;
        drive_cycle();
        n_cmp++;
        if (o_cmd !== cmd0) begin n_fail++; $display("FAIL rst_mid_restart: got %h required %h", o_cmd, cmd0); end
        repeat (D / 2 - 1) drive_cycle();
        req = 4'b0100; wr = '0; addr[2] = 3'd3;
        drive_cycle();
        n_cmp++;
        if (o_gnt !== 4'b0100) begin n_fail++; $display("FAIL rst_mid_gnt: got %b required 0100", o_gnt); end
        req = '0; rst = 1'b1;
        drive_cycle();
        rst = 1'b0;
        drive_cycle();
        n_cmp++;
        if (o_rv !== '0 || o_rv !== e_rv || o_cmd !== cmd0 || o_busy !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_read: rvalid=%b busy=%b cmd=%h required 0000/1/%h", o_rv, o_busy, o_cmd, cmd0);
        end
        repeat (D / 2 - 1) drive_cycle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            init_req = ($urandom_range(99) == 0);
            drive_cycle();
            n_cmp++;
            if (o_gnt !== e_gnt || o_busy !== e_busy) begin
                n_fail++; $display("FAIL rand_gnt c=%0d: gnt=%b busy=%b required %b/%b", c, o_gnt, o_busy, e_gnt, e_busy);
            end
            n_cmp++;
            if (o_rv !== e_rv || o_rd !== e_rd) begin
                n_fail++; $display("FAIL rand_read c=%0d: rvalid=%b rdata=%h required %b/%h", c, o_rv, o_rd, e_rv, e_rd);
            end
            for (int i = 0; i < NR; i++) begin
                if (req[i] && o_gnt[i]) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(2) != 0) new_op(i, 1'b1);
            end
        end
        init_req = 1'b0; req = '0;
        repeat (D) drive_cycle();
        for (int i = 0; i < D; i++) begin
            n_cmp++;
            if (mem[i] !== m_mem[i]) begin n_fail++; $display("FAIL rand_mem addr=%0d: got %h required %h", i, mem[i], m_mem[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_init_fill();
        test_all_reads();
        test_conflict();
        test_fairness();
        test_init_req();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
